// File: rtl/payment_engine_arbiter_if.sv
// rtl/payment_engine_arbiter_if.sv - requester and engine signal bundle for the payment engine arbiter
interface payment_engine_arbiter_if #(
    parameter int DW = 32
);
    logic [2:0]      req;
    logic [3*DW-1:0] req_num;
    logic [3*DW-1:0] req_amt;
    logic [15:0]     req_micr;
    logic [2:0]      grant;
    logic [2:0]      rsp_valid;
    logic            rsp_ok;
    logic [DW-1:0]   rsp_excess;
    logic            rsp_timeout;
    logic            eng_start;
    logic [1:0]      eng_type;
    logic [DW-1:0]   eng_num;
    logic [DW-1:0]   eng_amt;
    logic [15:0]     eng_micr;
    logic            eng_done;
    logic            eng_ok;
    logic [DW-1:0]   eng_excess;
    logic            busy;
    logic [7:0]      timeout_cnt;

    modport slave (
        input  req, req_num, req_amt, req_micr, eng_done, eng_ok, eng_excess,
        output grant, rsp_valid, rsp_ok, rsp_excess, rsp_timeout,
               eng_start, eng_type, eng_num, eng_amt, eng_micr, busy, timeout_cnt
    );

    modport master (
        output req, req_num, req_amt, req_micr, eng_done, eng_ok, eng_excess,
        input  grant, rsp_valid, rsp_ok, rsp_excess, rsp_timeout,
               eng_start, eng_type, eng_num, eng_amt, eng_micr, busy, timeout_cnt
    );
endinterface

// File: rtl/payment_engine_arbiter.sv
// rtl/payment_engine_arbiter.sv - round-robin share of one payment validation engine among cash, cheque and DD
module payment_engine_arbiter #(
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    payment_engine_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] owner;
    logic [7:0] timer;
    logic [1:0] pick;

    // Search starts just after the last winner; the final fallback is the only bit left.
    always_comb begin
        pick = 2'd0;
        case (rr_ptr)
            2'd0:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            rr_ptr          <= 2'd2;
            owner           <= 2'd0;
            timer           <= 8'd0;
            bus.grant       <= 3'b000;
            bus.rsp_valid   <= 3'b000;
            bus.rsp_ok      <= 1'b0;
            bus.rsp_excess  <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.eng_start   <= 1'b0;
            bus.eng_type    <= 2'd0;
            bus.eng_num     <= '0;
            bus.eng_amt     <= '0;
            bus.eng_micr    <= 16'd0;
            bus.busy        <= 1'b0;
            bus.timeout_cnt <= 8'd0;
        end else begin
            bus.grant     <= 3'b000;
            bus.eng_start <= 1'b0;
            bus.rsp_valid <= 3'b000;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        owner         <= pick;
                        bus.grant     <= 3'b001 << pick;
                        bus.eng_start <= 1'b1;
                        bus.eng_type  <= pick + 2'd1;
                        bus.eng_num   <= bus.req_num[pick*DW +: DW];
                        bus.eng_amt   <= bus.req_amt[pick*DW +: DW];
                        bus.eng_micr  <= (pick == 2'd1) ? bus.req_micr : 16'd0;
                        bus.busy      <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= 8'd0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle wins over the timeout.
                    if (bus.eng_done) begin
                        bus.rsp_ok      <= bus.eng_ok;
                        bus.rsp_excess  <= bus.eng_excess;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 3'b001 << owner;
                        state           <= S_RESP;
                    end else if (timer == TIMER_LAST) begin
                        bus.rsp_ok      <= 1'b0;
                        bus.rsp_excess  <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 3'b001 << owner;
                        if (bus.timeout_cnt != 8'hFF) begin
                            bus.timeout_cnt <= bus.timeout_cnt + 8'd1;
                        end
                        state <= S_RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_RESP: begin
                    rr_ptr          <= owner;
                    bus.rsp_ok      <= 1'b0;
                    bus.rsp_excess  <= '0;
                    bus.rsp_timeout <= 1'b0;
                    bus.eng_type    <= 2'd0;
                    bus.eng_num     <= '0;
                    bus.eng_amt     <= '0;
                    bus.eng_micr    <= 16'd0;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_payment_engine_arbiter.sv
// tb/tb_payment_engine_arbiter.sv - self-checking bench for payment_engine_arbiter
module tb_payment_engine_arbiter;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_w;
    int   tcount;
    int   grant_cyc;

    payment_engine_arbiter_if #(.DW(DW)) bus();

    payment_engine_arbiter #(.DW(DW), .TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] num;
        logic [31:0] amt;
        logic [15:0] micr;
        int          d;
        logic        ok;
        logic [31:0] ex;
        int          exp_w;
        logic        exp_to;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {bus.grant, bus.rsp_valid, bus.rsp_ok, bus.rsp_timeout,
              bus.eng_start, bus.eng_type, bus.busy, bus.timeout_cnt}, 0);
        check({name, "_data"}, {bus.rsp_excess, bus.eng_num, bus.eng_amt, bus.eng_micr}, 0);
    endtask

    function automatic int pick_model(input logic [2:0] m, input int last);
        for (int i = 1; i <= 3; i++) begin
            if (m[(last + i) % 3]) return (last + i) % 3;
        end
        return -1;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
    task automatic run_txn(input logic [2:0] mask, input logic [31:0] num_base, input logic [31:0] amt_base,
                           input logic [15:0] micr, input int d, input logic ok, input logic [31:0] ex,
                           input int exp_w, input logic exp_to, input logic hold);
        int   k;
        int   k_exp;
        logic got;
        bus.req      = mask;
        for (int i = 0; i < 3; i++) begin
            bus.req_num[i*DW +: DW] = num_base + 32'(i * 1000);
            bus.req_amt[i*DW +: DW] = amt_base + 32'(i * 7);
        end
        bus.req_micr = micr;
        bus.eng_done = 1'b0;
        @(negedge clk);
        check("grant", bus.grant, 3'b001 << exp_w);
        check("eng_start", bus.eng_start, 1);
        check("eng_type", bus.eng_type, exp_w + 1);
        check("eng_num", bus.eng_num, num_base + 32'(exp_w * 1000));
        check("eng_amt", bus.eng_amt, amt_base + 32'(exp_w * 7));
        check("eng_micr", bus.eng_micr, (exp_w == 1) ? micr : 16'd0);
        check("busy_issue", bus.busy, 1);
        grant_cyc = cyc;
        if (!hold) bus.req = 3'b000;
        @(negedge clk);
        check("start_pulse", bus.eng_start, 0);
        k = 0;
        got = 1'b0;
        while (!got && k < T + 4) begin
            bus.eng_done   = (k == d);
            bus.eng_ok     = ok;
            bus.eng_excess = ex;
            @(negedge clk);
            bus.eng_done = 1'b0;
            if (|bus.rsp_valid) got = 1'b1;
            else k++;
        end
        k_exp = exp_to ? T - 1 : d;
        check("rsp_arrived", got, 1);
        check("rsp_latency", k, k_exp);
        check("rsp_valid", bus.rsp_valid, 3'b001 << exp_w);
        check("rsp_ok", bus.rsp_ok, exp_to ? 1'b0 : ok);
        check("rsp_excess", bus.rsp_excess, exp_to ? 32'd0 : ex);
        check("rsp_timeout", bus.rsp_timeout, exp_to);
        if (exp_to && tcount < 255) tcount++;
        check("timeout_cnt", bus.timeout_cnt, tcount);
        @(negedge clk);
        check("idle_rsp", bus.rsp_valid, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_grant", bus.grant, 0);
        last_w = exp_w;
    endtask

    initial begin
        int w;
        int d;
        int prev_cyc;
        logic to;

        vecs[0] = '{3'b001, 32'd1234, 32'd100, 16'd0,    0,      1'b1, 32'd20, 0, 1'b0};
        vecs[1] = '{3'b111, 32'd11,   32'd22,  16'd5555, 2,      1'b0, 32'd7,  1, 1'b0};
        vecs[2] = '{3'b111, 32'd33,   32'd44,  16'd1,    1,      1'b1, 32'd0,  2, 1'b0};
        vecs[3] = '{3'b011, 32'd55,   32'd66,  16'd2,    0,      1'b1, 32'd3,  0, 1'b0};
        vecs[4] = '{3'b100, 32'd77,   32'd88,  16'd3,    5,      1'b1, 32'd4,  2, 1'b0};
        vecs[5] = '{3'b101, 32'd99,   32'd111, 16'd4,    T - 1,  1'b1, 32'd99, 0, 1'b0};
        vecs[6] = '{3'b110, 32'd500,  32'd600, 16'd4321, -1,     1'b1, 32'd9,  1, 1'b1};
        vecs[7] = '{3'b011, 32'd700,  32'd800, 16'd5,    T,      1'b1, 32'd8,  0, 1'b1};

        reset = 1'b1;
        bus.req = 3'b000; bus.req_num = '0; bus.req_amt = '0; bus.req_micr = 16'd0;
        bus.eng_done = 1'b0; bus.eng_ok = 1'b0; bus.eng_excess = '0;
        last_w = 2; tcount = 0; grant_cyc = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        foreach (vecs[i]) begin
            run_txn(vecs[i].mask, vecs[i].num, vecs[i].amt, vecs[i].micr, vecs[i].d,
                    vecs[i].ok, vecs[i].ex, vecs[i].exp_w, vecs[i].exp_to, 1'b0);
        end

        // All three requesters held high: strict rotation at one grant per 4 cycles.
        prev_cyc = 0;
        for (int j = 0; j < 6; j++) begin
            w = pick_model(3'b111, last_w);
            run_txn(3'b111, 32'(j * 10), 32'(j), 16'd0, 0, 1'b1, 32'(j), w, 1'b0, 1'b1);
            if (j > 0) check("b2b_spacing", grant_cyc - prev_cyc, 4);
            prev_cyc = grant_cyc;
        end
        bus.req = 3'b000;
        @(negedge clk);

        // Reset while waiting on the engine, then a stale done.
        bus.req = 3'b100;
        @(negedge clk);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_wait");
        reset = 1'b0;
        bus.eng_done = 1'b1; bus.eng_ok = 1'b1; bus.eng_excess = 32'd5;
        @(negedge clk);
        bus.eng_done = 1'b0;
        check("stale_done_rsp", bus.rsp_valid, 0);
        check("stale_done_busy", bus.busy, 0);
        last_w = 2; tcount = 0;
        run_txn(3'b111, 32'd42, 32'd43, 16'd0, 0, 1'b1, 32'd1, 0, 1'b0, 1'b0);

        // Cheque with a silent engine, then a late done after the timeout response.
        run_txn(3'b010, 32'd2000, 32'd300, 16'd9876, -1, 1'b1, 32'd55, 1, 1'b1, 1'b0);
        bus.eng_done = 1'b1; bus.eng_ok = 1'b1; bus.eng_excess = 32'd55;
        @(negedge clk);
        bus.eng_done = 1'b0;
        check("late_done_rsp", bus.rsp_valid, 0);
        check("late_done_busy", bus.busy, 0);
        check("late_done_grant", bus.grant, 0);
        @(negedge clk);
        check("late_done_rsp2", bus.rsp_valid, 0);
        check("late_done_cnt", bus.timeout_cnt, 1);

        for (int j = 0; j < 40; j++) begin
            logic [2:0] m;
            m = 3'($urandom_range(1, 7));
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 1));
            to = (d < 0) || (d > T - 1);
            w = pick_model(m, last_w);
            run_txn(m, $urandom, $urandom, 16'($urandom), d, 1'($urandom), $urandom, w, to, 1'b0);
        end

        for (int j = 0; j < 300; j++) begin
            logic [2:0] m;
            m = 3'($urandom_range(1, 7));
            w = pick_model(m, last_w);
            run_txn(m, $urandom, $urandom, 16'($urandom), -1, 1'b1, $urandom, w, 1'b1, 1'b0);
        end
        check("sat_cnt", bus.timeout_cnt, 255);
        w = pick_model(3'b111, last_w);
        run_txn(3'b111, 32'd9, 32'd9, 16'd9, T - 1, 1'b1, 32'd77, w, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
